// File: rtl/button_debouncer_if.sv
// Purpose : bundles the per-channel button pins and conditioned outputs of button_debouncer.
// Latency : n/a (wiring only).
// Backpressure: none; all signals are level/strobe outputs sampled every cycle.
//
// Signals (one bit per channel):
//   button_in      raw asynchronous pin levels (driven by the pin side)
//   button_level   debounced state, 1 = pressed
//   button_press   1-cycle pulse on an accepted press
//   button_release 1-cycle pulse on an accepted release
//   button_repeat  1-cycle pulse per auto-repeat tick while held
interface button_debouncer_if #(
    parameter int NUM_BUTTONS = 2
);
    logic [NUM_BUTTONS-1:0] button_in;
    logic [NUM_BUTTONS-1:0] button_level;
    logic [NUM_BUTTONS-1:0] button_press;
    logic [NUM_BUTTONS-1:0] button_release;
    logic [NUM_BUTTONS-1:0] button_repeat;

    // Pin / control side: drives the raw levels, consumes the conditioned outputs.
    modport master (
        output button_in,
        input  button_level,
        input  button_press,
        input  button_release,
        input  button_repeat
    );

    // Debouncer side.
    modport slave (
        input  button_in,
        output button_level,
        output button_press,
        output button_release,
        output button_repeat
    );
endinterface

// File: rtl/button_debouncer.sv
// Purpose : per-channel 2-FF sync, stability-counter debounce, level + press/release/repeat strobes.
// Latency : stable pin edge -> strobe/level change = 2 + DEBOUNCE_CYCLES + 1 clocks.
// Backpressure: none; strobes are single-cycle and must be consumed when they occur.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   btn    button_debouncer_if.slave: button_in (raw pins) in; button_level,
//          button_press, button_release, button_repeat out (one bit per channel)
module button_debouncer #(
    parameter int   NUM_BUTTONS         = 2,
    parameter logic ACTIVE_LEVEL        = 1'b1,
    parameter int   DEBOUNCE_CYCLES     = 270000,
    parameter int   REPEAT_DELAY_CYCLES = 13500000,
    parameter int   REPEAT_RATE_CYCLES  = 2700000
) (
    input  logic                clk,
    input  logic                reset,
    button_debouncer_if.slave   btn
);

    localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ? DEBOUNCE_CYCLES
                                                                     : REPEAT_DELAY_CYCLES;
    localparam int MAX_CYCLES = (MAX_DR > REPEAT_RATE_CYCLES) ? MAX_DR : REPEAT_RATE_CYCLES;
    // One spare bit so neither counter can wrap before its compare value.
    localparam int CW = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RPT_LAST   = CW'(REPEAT_DELAY_CYCLES - 1);
    // After the first repeat the counter restarts part-way so the next hit
    // comes REPEAT_RATE_CYCLES later using the same compare value.
    localparam logic [CW-1:0] RPT_RELOAD = CW'(REPEAT_DELAY_CYCLES - REPEAT_RATE_CYCLES);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic [NUM_BUTTONS-1:0] level_v;
    logic [NUM_BUTTONS-1:0] press_v;
    logic [NUM_BUTTONS-1:0] release_v;
    logic [NUM_BUTTONS-1:0] repeat_v;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        logic          sync1_q;
        logic          sync2_q;
        logic          s;
        state_t        state_q;
        state_t        state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic [CW-1:0] rpt_q;
        logic [CW-1:0] rpt_d;
        logic          press_d;
        logic          release_d;
        logic          repeat_d;
        logic          press_ev_q;
        logic          release_ev_q;
        logic          repeat_ev_q;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          repeat_q;

        // Synchroniser resets to the idle level so reset never looks like a press.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_q <= ~ACTIVE_LEVEL;
                sync2_q <= ~ACTIVE_LEVEL;
            end else begin
                sync1_q <= btn.button_in[g];
                sync2_q <= sync1_q;
            end
        end

        assign s = (sync2_q == ACTIVE_LEVEL);

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                rpt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rpt_q   <= rpt_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            rpt_d     = rpt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            repeat_d  = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_CHK;
                        cnt_d   = CW'(1);
                    end
                end
                PRESS_CHK: begin
                    if (!s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        rpt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        // rpt_q is left alone so a rejected bounce resumes the repeat timing.
                        state_d = RELEASE_CHK;
                        cnt_d   = CW'(1);
                    end else if (rpt_q == RPT_LAST) begin
                        rpt_d    = RPT_RELOAD;
                        repeat_d = 1'b1;
                    end else begin
                        rpt_d = rpt_q + CW'(1);
                    end
                end
                RELEASE_CHK: begin
                    if (s) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Events are captured on the deciding edge and presented one clock
        // later, together with the level derived from the registered state,
        // so level and its strobe always change in the same cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                press_ev_q   <= 1'b0;
                release_ev_q <= 1'b0;
                repeat_ev_q  <= 1'b0;
                level_q      <= 1'b0;
                press_q      <= 1'b0;
                release_q    <= 1'b0;
                repeat_q     <= 1'b0;
            end else begin
                press_ev_q   <= press_d;
                release_ev_q <= release_d;
                repeat_ev_q  <= repeat_d;
                level_q      <= (state_q == HELD) || (state_q == RELEASE_CHK);
                press_q      <= press_ev_q;
                release_q    <= release_ev_q;
                repeat_q     <= repeat_ev_q;
            end
        end

        assign level_v[g]   = level_q;
        assign press_v[g]   = press_q;
        assign release_v[g] = release_q;
        assign repeat_v[g]  = repeat_q;
    end

    assign btn.button_level   = level_v;
    assign btn.button_press   = press_v;
    assign btn.button_release = release_v;
    assign btn.button_repeat  = repeat_v;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: an active-high and an active-low instance see
// complementary pins, so both must match the same reference model cycle for cycle.
module tb_button_debouncer;

    localparam int NB = 2;
    localparam int DB = 8;
    localparam int RD = 40;
    localparam int RR = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    button_debouncer_if #(.NUM_BUTTONS(NB)) if0 ();
    button_debouncer_if #(.NUM_BUTTONS(NB)) if1 ();

    assign if1.button_in = ~if0.button_in;

    button_debouncer #(
        .NUM_BUTTONS(NB), .ACTIVE_LEVEL(1'b1), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR)
    ) dut_hi (
        .clk(clk), .reset(reset), .btn(if0)
    );

    button_debouncer #(
        .NUM_BUTTONS(NB), .ACTIVE_LEVEL(1'b0), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR)
    ) dut_lo (
        .clk(clk), .reset(reset), .btn(if1)
    );

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
        logic [NB-1:0] rpt;
    } obs_t;

    obs_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check_int(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic sb_compare(input string who, input obs_t got, input obs_t e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL sb_%s cycle %0d: got lvl=%b prs=%b rel=%b rpt=%b, expected lvl=%b prs=%b rel=%b rpt=%b",
                     who, cyc, got.lvl, got.prs, got.rel, got.rpt, e.lvl, e.prs, e.rel, e.rpt);
        end
    endtask

    // Reference model: a change is accepted once the synchronised input has
    // disagreed with the accepted level for DB consecutive cycles; repeats fire
    // on the RD-th uninterrupted held cycle and every RR held cycles after.
    // Every visible output lags the accepting decision by one clock.
    initial begin : model
        bit   d1  [NB];
        bit   d2  [NB];
        bit   acc [NB];
        int   run [NB];
        int   held[NB];
        bit [2:0] evl[NB];
        bit [2:0] ev;
        bit   s;
        obs_t e;
        for (int c = 0; c < NB; c++) begin
            d1[c] = 0; d2[c] = 0; acc[c] = 0; run[c] = 0; held[c] = 0; evl[c] = '0;
        end
        forever begin
            @(posedge clk);
            e = '0;
            if (reset) begin
                for (int c = 0; c < NB; c++) begin
                    d1[c] = 0; d2[c] = 0; acc[c] = 0; run[c] = 0; held[c] = 0; evl[c] = '0;
                end
            end else begin
                for (int c = 0; c < NB; c++) begin
                    e.lvl[c] = acc[c];
                    e.prs[c] = evl[c][0];
                    e.rel[c] = evl[c][1];
                    e.rpt[c] = evl[c][2];
                    s     = d2[c];
                    d2[c] = d1[c];
                    d1[c] = if0.button_in[c];
                    ev    = 3'b000;
                    if (s != acc[c]) begin
                        run[c]++;
                        if (run[c] == DB) begin
                            acc[c] = s;
                            run[c] = 0;
                            if (s) begin
                                ev[0]   = 1'b1;
                                held[c] = 0;
                            end else begin
                                ev[1] = 1'b1;
                            end
                        end
                    end else begin
                        if (acc[c] && run[c] == 0) begin
                            held[c]++;
                            if (held[c] >= RD && (held[c] - RD) % RR == 0) ev[2] = 1'b1;
                        end
                        run[c] = 0;
                    end
                    evl[c] = ev;
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: every cycle presents an output word; pop and compare both builds.
    initial begin : monitor
        obs_t e;
        obs_t g0;
        obs_t g1;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                g0 = {if0.button_level, if0.button_press, if0.button_release, if0.button_repeat};
                g1 = {if1.button_level, if1.button_press, if1.button_release, if1.button_repeat};
                sb_compare("hi", g0, e);
                sb_compare("lo", g1, e);
            end
        end
    end

    // Directed measurement: index 0 is the first output cycle after the pin edge.
    int            m_first [3];
    int            m_cnt   [3];
    int            m1_first[3];
    logic [NB-1:0] m_pbus;

    task automatic measure(input int ch, input int n);
        logic [2:0] v0;
        logic [2:0] v1;
        for (int k = 0; k < 3; k++) begin
            m_first[k] = -1; m_cnt[k] = 0; m1_first[k] = -1;
        end
        m_pbus = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v0 = {if0.button_repeat[ch], if0.button_release[ch], if0.button_press[ch]};
            v1 = {if1.button_repeat[ch], if1.button_release[ch], if1.button_press[ch]};
            for (int k = 0; k < 3; k++) begin
                if (v0[k]) begin
                    m_cnt[k]++;
                    if (m_first[k] < 0) begin
                        m_first[k] = i;
                        if (k == 0) m_pbus = if0.button_press;
                    end
                end
                if (v1[k] && m1_first[k] < 0) m1_first[k] = i;
            end
        end
    endtask

    task automatic drive(input logic [NB-1:0] v);
        @(posedge clk);
        #1 if0.button_in = v;
    endtask

    initial begin : stim
        int acc_cnt;
        int hl[NB];
        logic [NB-1:0] pv;

        if0.button_in = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_int("reset_level", int'(if0.button_level), 0);
        check_int("reset_press", int'(if0.button_press), 0);
        repeat (4) @(posedge clk);

        // Clean press on channel 0, held 100 clocks.
        drive(2'b01);
        measure(0, 100);
        check_int("press_latency", m_first[0], 11);
        check_int("press_count", m_cnt[0], 1);
        check_int("active_low_press_latency", m1_first[0], 11);
        check_int("first_repeat", m_first[2], 51);
        check_int("repeat_count", m_cnt[2], 5);
        check_int("level_held", int'(if0.button_level[0]), 1);

        // Release with bounce: 5 low, 3 high, then low for good.
        drive(2'b00);
        measure(0, 5);
        acc_cnt = m_cnt[1];
        drive(2'b01);
        measure(0, 3);
        acc_cnt += m_cnt[1];
        check_int("bounce_no_release", acc_cnt, 0);
        drive(2'b00);
        measure(0, 30);
        check_int("release_latency", m_first[1], 11);
        check_int("release_count", m_cnt[1], 1);
        check_int("no_repeat_after_release", m_cnt[2], 0);
        check_int("level_released", int'(if0.button_level[0]), 0);

        // Glitches on channel 1: 1-clock and 7-clock pulses.
        drive(2'b10); measure(1, 1);  acc_cnt = m_cnt[0];
        drive(2'b00); measure(1, 10); acc_cnt += m_cnt[0];
        drive(2'b10); measure(1, 7);  acc_cnt += m_cnt[0];
        drive(2'b00); measure(1, 20); acc_cnt += m_cnt[0];
        check_int("glitch_no_press", acc_cnt, 0);
        check_int("glitch_level", int'(if0.button_level[1]), 0);

        // Both channels pressed on the same clock, then only channel 1 released.
        drive(2'b11);
        measure(0, 20);
        check_int("dual_press_latency", m_first[0], 11);
        check_int("dual_press_both", int'(m_pbus), 3);
        drive(2'b01);
        measure(1, 20);
        check_int("dual_release_ch1", m_first[1], 11);
        check_int("dual_ch0_level", int'(if0.button_level[0]), 1);
        check_int("dual_ch1_level", int'(if0.button_level[1]), 0);

        // One-clock reset while channel 0 is held.
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_int("reset_hold_level", int'(if0.button_level), 0);
        check_int("reset_hold_no_release", int'(if0.button_release), 0);
        // The first post-reset output cycle was consumed above, so 11 becomes 10.
        measure(0, 20);
        check_int("reset_repress_latency", m_first[0], 10);
        check_int("reset_repress_lo", m1_first[0], 10);

        drive(2'b00);
        repeat (30) @(posedge clk);

        // Randomised holds of short (bouncy) and long (repeating) lengths.
        pv = '0;
        for (int c = 0; c < NB; c++) hl[c] = 0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NB; c++) begin
                if (hl[c] == 0) begin
                    pv[c] = 1'($urandom_range(0, 1));
                    hl[c] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 9))
                                                        : int'($urandom_range(10, 70));
                end
                hl[c]--;
            end
            if0.button_in = pv;
            reset = ($urandom_range(0, 599) == 0);
        end
        #1 reset = 1'b0;
        if0.button_in = '0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions the raw board push-buttons (KEY1/KEY2) before they reach the HDMI labo control logic.
- Per channel:
  - 2-FF synchroniser.
  - Stability-counter debounce.
  - Debounced level output.
  - Single-cycle press/release strobes.
  - Auto-repeat strobes while a button is held.
- Sits directly between the top-level button pins and the mode/pattern control state in tangnano20k_hdmi_labo.

Parameters:
- NUM_BUTTONS, 2: number of independent channels.
- ACTIVE_LEVEL, 1'b1: raw pin level meaning "pressed".
- DEBOUNCE_CYCLES, 270000: consecutive stable cycles required to accept a change (10 ms at 27 MHz); legal range 2..2^20-1.
- REPEAT_DELAY_CYCLES, 13500000: hold time after the accepted press before the first repeat strobe (500 ms).
- REPEAT_RATE_CYCLES, 2700000: period between subsequent repeat strobes (100 ms).

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- button_in, input, NUM_BUTTONS: raw asynchronous pin levels.
- button_level, output, NUM_BUTTONS: debounced state, 1 = pressed.
- button_press, output, NUM_BUTTONS: 1-cycle pulse on accepted press.
- button_release, output, NUM_BUTTONS: 1-cycle pulse on accepted release.
- button_repeat, output, NUM_BUTTONS: 1-cycle pulse per auto-repeat tick while held.

Behaviour:
- Reset:
  - All outputs are 0.
  - Synchroniser FFs are loaded with the not-pressed level (~ACTIVE_LEVEL).
  - All counters are 0; every channel enters IDLE.
- Synchroniser:
  - Two flops per channel, then normalisation: s = (sync2 == ACTIVE_LEVEL).
  - Pin-to-s latency is 2 clocks.
- Per-channel FSM, states IDLE, PRESS_CHK, HELD, RELEASE_CHK:
  - IDLE (level=0):
    - s=1 -> PRESS_CHK, cnt=1.
  - PRESS_CHK:
    - s=0 -> IDLE, cnt=0 (glitch rejected; no strobes).
    - s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD. On the next clock, level=1 and press pulses for exactly 1 cycle. rpt_cnt=0.
    - Otherwise cnt+1.
  - HELD (level=1):
    - s=0 -> RELEASE_CHK, cnt=1. The repeat counter is frozen, not cleared.
    - Otherwise rpt_cnt+1:
      - First repeat pulse when rpt_cnt reaches REPEAT_DELAY_CYCLES-1; rpt_cnt then reloads to REPEAT_DELAY_CYCLES-REPEAT_RATE_CYCLES.
      - Subsequent pulses every REPEAT_RATE_CYCLES.
  - RELEASE_CHK (level stays 1):
    - s=1 -> HELD, cnt=0. Bounce rejected; rpt_cnt resumes from its frozen value; no strobes.
    - s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. On the next clock, level=0 and release pulses for 1 cycle.
- Latency: raw edge held stable -> press/release strobe = 2 (sync) + DEBOUNCE_CYCLES + 1 clocks.
- Strobe exclusivity per channel: press, release and repeat are never asserted in the same cycle; press is never followed by repeat within REPEAT_DELAY_CYCLES.
- Channels are fully independent; simultaneous activity on several channels produces simultaneous strobes.
- Counter widths are $clog2 of the largest parameter plus 1, so there is no wrap-around. rpt_cnt saturation is not needed because of the reload.
- Reset mid-operation: all outputs drop to 0 in the cycle after reset is sampled high, with no release strobe. A button held through reset is re-detected as a new press after the full debounce.
- Generate-loop over channels; no cross-channel shared state.

Test Plan:
- Bench parameter override: DEBOUNCE_CYCLES=8, REPEAT_DELAY_CYCLES=40, REPEAT_RATE_CYCLES=10, ACTIVE_LEVEL=1.
- Clean press:
  - Stimulus: button_in[0] 0->1, held 100 clocks.
  - Required: button_press[0] high for exactly 1 cycle, 11 clocks after the edge. button_level[0]=1 from that cycle on. Repeats at +40, +50, +60, +70, +80, +90 clocks after the press strobe.
- Glitch rejection:
  - Stimulus: 1-clock and 7-clock high pulses on button_in[1].
  - Required: no press strobe; button_level[1] stays 0.
- Release with bounce:
  - Stimulus: while held, drop to 0 for 5 clocks, return to 1 for 3 clocks, then 0 permanently.
  - Required: no release during the bounce; a single button_release pulse 11 clocks after the final falling edge; no repeat after the release.
- Dual channel:
  - Stimulus: both buttons pressed on the same clock.
  - Required: button_press == 2'b11 on the same cycle; one channel's release does not affect the other's level.
- Reset mid-hold:
  - Stimulus: assert reset for 1 clock during HELD with the button still pressed.
  - Required: level=0 on the next clock with no release pulse; a fresh press strobe 11 clocks after reset deasserts.
- Active-low build:
  - Stimulus: ACTIVE_LEVEL=0, idle pin=1, then pin driven low.
  - Required: the press strobe timing matches the clean-press scenario.
